// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size encodings,
// lane widths, the controller state enum and small alignment helpers.
package mau_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Lane geometry of the 32-bit data memory word
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int LANES  = WORD_W / BYTE_W;

  // Controller states
  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    ST_WR,
    RMW_RD,
    RMW_CAP,
    RMW_WR
  } mau_state_e;

  // True when the low address bits are not a multiple of the access size
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

  // Clears the address bits below the access size (half keeps addr[1], word uses lane 0)
  function automatic logic [1:0] force_lo(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] r;
    case (size)
      SZ_HALF: r = {lo[1], 1'b0};
      SZ_WORD: r = 2'b00;
      default: r = lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic for the load/store unit: extracts and extends the
// addressed lane of a loaded word, and merges sub-word store data into a word
// read back from memory. Lanes are little-endian (byte k at bits [8k+7:8k]).
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;
  logic [LANES-1:0]  byte_en;
  logic [WORD_W-1:0] store_rep;

  // Pick the addressed byte and halfword out of the loaded word
  always_comb begin
    byte_sel = word[BYTE_W-1:0];
    case (addr_lo)
      2'd1:    byte_sel = word[2*BYTE_W-1:BYTE_W];
      2'd2:    byte_sel = word[3*BYTE_W-1:2*BYTE_W];
      2'd3:    byte_sel = word[4*BYTE_W-1:3*BYTE_W];
      default: byte_sel = word[BYTE_W-1:0];
    endcase
    half_sel = addr_lo[1] ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  end

  // Sign- or zero-extend the selected lane to a full word
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {{(WORD_W-BYTE_W){1'b0}}, byte_sel}
                                       : {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {{(WORD_W-HALF_W){1'b0}}, half_sel}
                                       : {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      default: load_data = word;
    endcase
  end

  // Byte enables and store data replicated into every lane it could land in
  always_comb begin
    byte_en   = '1;
    store_rep = wdata;
    case (size)
      SZ_BYTE: begin
        byte_en   = LANES'(1) << addr_lo;
        store_rep = {LANES{wdata[BYTE_W-1:0]}};
      end
      SZ_HALF: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{wdata[HALF_W-1:0]}};
      end
      default: begin
        byte_en   = '1;
        store_rep = wdata;
      end
    endcase
  end

  // Per-lane merge: enabled lanes take store data, others keep the memory word
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
      assign merged[gi*BYTE_W +: BYTE_W] = byte_en[gi] ? store_rep[gi*BYTE_W +: BYTE_W]
                                                       : word[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide, byte-addressed data memory.
// Loads take two edges after accept; word stores one; byte/half stores are done
// as read-modify-write. All memory-side and response outputs are registered.
// Build option MAU_MISALIGN_CHECK_EN: when defined, misaligned half/word accesses
// are rejected; when undefined, the sub-size address bits are forced to zero.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Highest address at which a full word still fits in the memory
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  mau_state_e state_reg, state_next;

  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              resp_valid_reg, resp_valid_next;
  logic [31:0]       resp_rdata_reg, resp_rdata_next;
  logic              err_valid_reg, err_valid_next;
  logic [ADDR_W-1:0] err_addr_reg, err_addr_next;

  // Request fields held for the duration of an access
  logic [1:0]  size_reg;
  logic [1:0]  addr_lo_reg;
  logic        unsigned_reg;
  logic [31:0] wdata_reg;

  logic        size_bad;
  logic        out_of_range;
  logic        misalign;
  logic        req_err;
  logic        accept_ok;
  logic [1:0]  req_lo;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Classify the presented request; alignment handling depends on the build option
  always_comb begin
    size_bad     = (req_size == SZ_RSVD);
    out_of_range = (req_addr > LAST_WORD);
`ifdef MAU_MISALIGN_CHECK_EN
    misalign     = misaligned(req_size, req_addr[1:0]);
    req_lo       = req_addr[1:0];
`else
    misalign     = 1'b0;
    req_lo       = force_lo(req_size, req_addr[1:0]);
`endif
    req_err      = size_bad || out_of_range || misalign;
    accept_ok    = (state_reg == IDLE) && req_valid && !req_err;
  end

  mau_lane_align u_align (
    .size        (size_reg),
    .addr_lo     (addr_lo_reg),
    .is_unsigned (unsigned_reg),
    .word        (mem_rdata),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .merged      (merged)
  );

  // Next-state and next-output logic of the access sequencer
  always_comb begin
    state_next      = state_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    resp_valid_next = 1'b0;
    resp_rdata_next = resp_rdata_reg;
    err_valid_next  = 1'b0;
    err_addr_next   = err_addr_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            err_valid_next = 1'b1;
            err_addr_next  = req_addr;
          end else begin
            mem_addr_next = {req_addr[ADDR_W-1:2], 2'b00};
            if (!req_write) begin
              mem_read_next = 1'b1;
              state_next    = LD_RD;
            end else if (req_size == SZ_WORD) begin
              mem_write_next = 1'b1;
              mem_wdata_next = req_wdata;
              state_next     = ST_WR;
            end else begin
              mem_read_next = 1'b1;
              state_next    = RMW_RD;
            end
          end
        end
      end
      LD_RD:  state_next = LD_CAP;
      LD_CAP: begin
        resp_rdata_next = load_data;
        resp_valid_next = 1'b1;
        state_next      = IDLE;
      end
      ST_WR:   state_next = IDLE;
      RMW_RD:  state_next = RMW_CAP;
      RMW_CAP: begin
        mem_wdata_next = merged;
        mem_write_next = 1'b1;
        state_next     = RMW_WR;
      end
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Registered memory-side and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      err_valid_reg  <= 1'b0;
      err_addr_reg   <= '0;
    end else begin
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_rdata_reg <= resp_rdata_next;
      err_valid_reg  <= err_valid_next;
      err_addr_reg   <= err_addr_next;
    end
  end

  // Capture request fields on the accept edge only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_reg     <= SZ_BYTE;
      addr_lo_reg  <= 2'b00;
      unsigned_reg <= 1'b0;
      wdata_reg    <= '0;
    end else if (accept_ok) begin
      size_reg     <= req_size;
      addr_lo_reg  <= req_lo;
      unsigned_reg <= req_unsigned;
      wdata_reg    <= req_wdata;
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign mem_read   = mem_read_reg;
  assign mem_write  = mem_write_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_rdata = resp_rdata_reg;
  assign err_valid  = err_valid_reg;
  assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: behavioural data memory preloaded with
// byte[i] = i[7:0], a table of directed transactions with hand-computed results,
// and hand-written sequences for reset state and reset during a read-modify-write.
module tb_mem_access_unit;

`ifdef MAU_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  logic [31:0] mem [256];

  mem_access_unit #(.ADDR_W(32), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous data memory: read data appears one edge after mem_read is sampled
  always @(posedge clk) begin
    if (mem_read)  mem_rdata <= mem[mem_addr[9:2]];
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] exp;   // load result, or word written for stores
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0]  rd_m, wr_m, busy_m, resp_m, err_m;
    logic [4:0]  e_rd, e_wr, e_busy, e_resp, e_err;
    logic [31:0] got_rdata, got_wdata, got_maddr, got_eaddr;
    int n;
    rd_m = '0; wr_m = '0; busy_m = '0; resp_m = '0; err_m = '0;
    got_rdata = '0; got_wdata = '0; got_maddr = '0; got_eaddr = '0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", idx, {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rd_m[k]   = mem_read;
      wr_m[k]   = mem_write;
      busy_m[k] = !req_ready;
      resp_m[k] = resp_valid;
      err_m[k]  = err_valid;
      if (resp_valid) got_rdata = resp_rdata;
      if (mem_write)  got_wdata = mem_wdata;
      if (mem_read || mem_write) got_maddr = mem_addr;
      if (err_valid)  got_eaddr = err_addr;
    end
    // Expected cycle signature, sample k taken between edges T+k and T+k+1
    if (v.err) begin
      e_rd = 5'b0; e_wr = 5'b0; e_busy = 5'b0; e_resp = 5'b0; e_err = 5'b00001;
    end else if (!v.wr) begin
      e_rd = 5'b00001; e_wr = 5'b0; e_busy = 5'b00011; e_resp = 5'b00100; e_err = 5'b0;
    end else if (v.size == 2'b10) begin
      e_rd = 5'b0; e_wr = 5'b00001; e_busy = 5'b00001; e_resp = 5'b0; e_err = 5'b0;
    end else begin
      e_rd = 5'b00001; e_wr = 5'b00100; e_busy = 5'b00111; e_resp = 5'b0; e_err = 5'b0;
    end
    chk("mem_read_cycles",  idx, {27'b0, rd_m},   {27'b0, e_rd});
    chk("mem_write_cycles", idx, {27'b0, wr_m},   {27'b0, e_wr});
    chk("busy_cycles",      idx, {27'b0, busy_m}, {27'b0, e_busy});
    chk("resp_cycles",      idx, {27'b0, resp_m}, {27'b0, e_resp});
    chk("err_cycles",       idx, {27'b0, err_m},  {27'b0, e_err});
    if (v.err) begin
      chk("err_addr", idx, got_eaddr, v.addr);
    end else begin
      chk("mem_addr", idx, got_maddr, {v.addr[31:2], 2'b00});
      if (v.wr) chk("mem_wdata", idx, got_wdata, v.exp);
      else      chk("resp_rdata", idx, got_rdata, v.exp);
    end
    $display("txn %0d wr=%0d size=%0d uns=%0d addr=%h wdata=%h err=%0d rdata=%h wmem=%h",
             idx, v.wr, v.size, v.uns, v.addr, v.wdata, err_m[0], got_rdata, got_wdata);
  endtask

  initial begin
    logic [4:0] rst_wr;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    end
    mem_rdata    = '0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    // Asynchronous reset: outputs settle without any clock edge
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready",  -1, {31'b0, req_ready},  32'd1);
    chk("rst_resp_valid", -1, {31'b0, resp_valid}, 32'd0);
    chk("rst_err_valid",  -1, {31'b0, err_valid},  32'd0);
    chk("rst_mem_rw",     -1, {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_resp_rdata", -1, resp_rdata, 32'd0);
    chk("rst_err_addr",   -1, err_addr,   32'd0);
    chk("rst_mem_addr",   -1, mem_addr,   32'd0);
    chk("rst_mem_wdata",  -1, mem_wdata,  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //                wr    size   uns   addr          wdata         err         exp
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h083, 32'h0,        1'b0, 32'hFFFFFF83});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h083, 32'h0,        1'b0, 32'h00000083});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h082, 32'h0,        1'b0, 32'hFFFF8382});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h082, 32'h0,        1'b0, 32'h00008382});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        1'b0, 32'h13121110});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        MIS,  32'h03020100});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h081, 32'h0,        MIS,  32'hFFFF8180});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h07F, 32'h0,        1'b0, 32'h0000007F});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hFFFEFDFC});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h3FE, 32'h1,        1'b1, 32'h0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h040, 32'h0,        1'b1, 32'h0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 1'b0, 32'h0302AB00});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        1'b0, 32'h0302AB00});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h202, 32'h0,        1'b0, 32'hFFFFDEAD});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h206, 32'h00001234, 1'b0, 32'h12340504});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h204, 32'h0,        1'b0, 32'h12340504});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h203, 32'hFFFFFF11, 1'b0, 32'h11ADBEEF});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h200, 32'h0,        1'b0, 32'h11ADBEEF});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h208, 32'hFFFF5678, 1'b0, 32'h0B0A5678});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h20A, 32'h0,        1'b0, 32'h00000B0A});

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while the RMW of sb 0x55 -> 0x300 sits in RMW_CAP: the write must never happen
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h55;
    @(posedge clk);            // accept edge T
    #1 req_valid = 1'b0;
    @(posedge clk);            // edge T+1: now in RMW_CAP
    #1 rst_n = 1'b0;
    rst_wr = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst_wr[k] = mem_write;
    end
    chk("rst_mid_no_write",  100, {27'b0, rst_wr}, 32'd0);
    chk("rst_mid_ready",     100, {31'b0, req_ready}, 32'd1);
    chk("rst_mid_mem_read",  100, {31'b0, mem_read}, 32'd0);
    chk("rst_mid_mem_wdata", 100, mem_wdata, 32'd0);
    rst_n = 1'b1;
    begin
      vec_t v;
      v = '{1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h03020100};
      run_vec(v, 101);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
